// File: rtl/user_input_ctrl_pkg.sv
// Shared types and constants for the user input controller and its key debouncer.
// FSM state encoding, key polarity and default debounce length live here.
package user_input_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_PRESS,
        ST_WAIT_RELEASE,
        ST_ACK
    } state_t;

    localparam logic KEY_PRESSED  = 1'b0;
    localparam logic KEY_RELEASED = 1'b1;

    // 10 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/user_input_ctrl_key_debouncer.sv
// Purpose: synchronise and debounce the active-low confirm key; flag accepted press/release edges.
// Latency: 2+DEBOUNCE_CYCLES cycles pin-to-event (2 cycles when USER_INPUT_DEBOUNCE_EN is undefined).
// Backpressure: none; events are single-cycle strobes coincident with the key_stable update.
module key_debouncer
    import user_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_stable,
    output logic press_evt,
    output logic release_evt
);

    logic key_s1;
    logic key_s2;
    logic accept;
    logic key_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_s1 <= KEY_RELEASED;
            key_s2 <= KEY_RELEASED;
        end else begin
            key_s1 <= key_raw;
            key_s2 <= key_s1;
        end
    end

`ifdef USER_INPUT_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CNT_W-1:0] cnt;
    logic             key_q;

    assign accept   = (key_s2 != key_q) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign key_next = key_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            key_q <= KEY_RELEASED;
        end else if (key_s2 == key_q) begin
            cnt <= '0;
        end else if (accept) begin
            key_q <= key_s2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign key_stable = key_q;
`else
    // Events fire on the cycle the second sync flop takes the new level.
    assign accept     = (key_s1 != key_s2);
    assign key_next   = key_s1;
    assign key_stable = key_s2;
`endif

    assign press_evt   = accept && (key_next == KEY_PRESSED);
    assign release_evt = accept && (key_next == KEY_RELEASED);

endmodule

// File: rtl/user_input_ctrl.sv
// Purpose: service CPU input requests from switches + debounced confirm key (USER_INPUT_DEBOUNCE_EN enables debounce).
// Latency: value captured on accepted press; input_valid pulses on the accepted release.
// Backpressure: input_wait stalls the CPU while pending; input_req must drop for a cycle between requests.
module user_input_ctrl
    import user_input_ctrl_pkg::*;
#(
    parameter int SW_W            = 4,
    parameter int DATA_W          = 32,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic              input_req,
    input  logic [SW_W-1:0]   SW,
    input  logic              key_n,
    output logic [DATA_W-1:0] user_input,
    output logic              input_valid,
    output logic              input_wait
);

    logic [SW_W-1:0] sw_s1;
    logic [SW_W-1:0] sw_sync;
    logic            key_stable;
    logic            press_evt;
    logic            release_evt;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] user_input_nxt;
    logic              valid_nxt;
    logic              wait_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_s1   <= '0;
            sw_sync <= '0;
        end else begin
            sw_s1   <= SW;
            sw_sync <= sw_s1;
        end
    end

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debouncer (
        .clk        (clk),
        .reset      (reset),
        .key_raw    (key_n),
        .key_stable (key_stable),
        .press_evt  (press_evt),
        .release_evt(release_evt)
    );

    always_comb begin
        state_nxt      = state;
        user_input_nxt = user_input;
        valid_nxt      = 1'b0;
        wait_nxt       = input_wait;
        if (halt) begin
            state_nxt = ST_IDLE;
            wait_nxt  = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (input_req) begin
                        state_nxt = ST_ARM;
                        wait_nxt  = 1'b1;
                    end
                end
                // A key already held when the request arrives must be released first.
                ST_ARM: begin
                    if (!input_req) begin
                        state_nxt = ST_IDLE;
                        wait_nxt  = 1'b0;
                    end else if (key_stable == KEY_RELEASED) begin
                        state_nxt = ST_WAIT_PRESS;
                    end
                end
                ST_WAIT_PRESS: begin
                    if (!input_req) begin
                        state_nxt = ST_IDLE;
                        wait_nxt  = 1'b0;
                    end else if (press_evt) begin
                        user_input_nxt = DATA_W'(sw_sync);
                        state_nxt      = ST_WAIT_RELEASE;
                    end
                end
                ST_WAIT_RELEASE: begin
                    if (!input_req) begin
                        state_nxt = ST_IDLE;
                        wait_nxt  = 1'b0;
                    end else if (release_evt) begin
                        valid_nxt = 1'b1;
                        wait_nxt  = 1'b0;
                        state_nxt = ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!input_req) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    wait_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            user_input  <= '0;
            input_valid <= 1'b0;
            input_wait  <= 1'b0;
        end else begin
            state       <= state_nxt;
            user_input  <= user_input_nxt;
            input_valid <= valid_nxt;
            input_wait  <= wait_nxt;
        end
    end

endmodule

// File: tb/tb_user_input_ctrl.sv
// Directed + randomized bench for user_input_ctrl; acceptance latency follows USER_INPUT_DEBOUNCE_EN.
module tb_user_input_ctrl;

    localparam int DC = 4;
`ifdef USER_INPUT_DEBOUNCE_EN
    localparam int LAT = DC + 2;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        reset;
    logic        halt;
    logic        input_req;
    logic [3:0]  SW;
    logic        key_n;
    logic [31:0] user_input;
    logic        input_valid;
    logic        input_wait;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          pulse_cnt = 0;
    logic [31:0] exp_user = '0;

    user_input_ctrl #(
        .SW_W           (4),
        .DATA_W         (32),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .halt       (halt),
        .input_req  (input_req),
        .SW         (SW),
        .key_n      (key_n),
        .user_input (user_input),
        .input_valid(input_valid),
        .input_wait (input_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (input_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete request: press captures sw, release completes after LAT cycles.
    task automatic do_read(input logic [3:0] sw, input int hold, input int gap);
        int base;
        SW        = sw;
        input_req = 1'b1;
        tick(3);
        check("wait_armed", 32'(input_wait), 32'd1);
        key_n = 1'b0;
        tick(LAT - 1);
        check("pre_capture", user_input, exp_user);
        tick(1);
        exp_user = {28'd0, sw};
        check("capture", user_input, exp_user);
        SW = ~sw;
        tick(hold);
        key_n = 1'b1;
        base  = pulse_cnt;
        tick(LAT - 1);
        check("valid_early", 32'(input_valid), 32'd0);
        check("wait_held", 32'(input_wait), 32'd1);
        tick(1);
        check("valid_pulse", 32'(input_valid), 32'd1);
        check("wait_fall", 32'(input_wait), 32'd0);
        check("user_hold", user_input, exp_user);
        tick(1);
        check("valid_single", 32'(input_valid), 32'd0);
        input_req = 1'b0;
        tick(gap);
        check("pulse_count", 32'(pulse_cnt), 32'(base + 1));
    endtask

    initial begin
        int base;
        logic [3:0] r;
        reset     = 1'b0;
        halt      = 1'b0;
        input_req = 1'b1;
        SW        = 4'hF;
        key_n     = 1'b0;

        // Reset with request and key active
        tick(3);
        check("rst_user", user_input, 32'd0);
        check("rst_valid", 32'(input_valid), 32'd0);
        check("rst_wait", 32'(input_wait), 32'd0);
        input_req = 1'b0;
        key_n     = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(LAT + 3);
        check("idle_no_req", 32'(input_wait), 32'd0);

        // Basic read
        do_read(4'b1010, 10, 2);

        // Randomized reads
        for (int i = 0; i < 5; i++) begin
            r = 4'($urandom_range(0, 15));
            do_read(r, int'($urandom_range(1, 8)), int'($urandom_range(1, 4)));
        end

`ifdef USER_INPUT_DEBOUNCE_EN
        // Bouncy press, glitchy release
        SW        = 4'h6;
        input_req = 1'b1;
        tick(3);
        base = pulse_cnt;
        for (int i = 0; i < 6; i++) begin
            key_n = ~key_n;
            tick(2);
        end
        check("bounce_nocap", user_input, exp_user);
        key_n = 1'b0;
        tick(LAT - 1);
        check("bounce_pre", user_input, exp_user);
        tick(1);
        exp_user = 32'd6;
        check("bounce_cap", user_input, exp_user);
        tick(3);
        key_n = 1'b1;
        tick(int'($urandom_range(1, 3)));
        key_n = 1'b0;
        tick(LAT + 2);
        check("glitch_valid", 32'(input_valid), 32'd0);
        check("glitch_wait", 32'(input_wait), 32'd1);
        check("glitch_pulses", 32'(pulse_cnt), 32'(base));
        key_n = 1'b1;
        tick(LAT - 1);
        check("bounce_early", 32'(input_valid), 32'd0);
        tick(1);
        check("bounce_valid", 32'(input_valid), 32'd1);
        tick(1);
        input_req = 1'b0;
        tick(2);
        check("bounce_pulses", 32'(pulse_cnt), 32'(base + 1));
`endif

        // Key already held when the request arrives
        SW    = 4'h9;
        key_n = 1'b0;
        tick(LAT + 2);
        base      = pulse_cnt;
        input_req = 1'b1;
        tick(LAT + 6);
        check("held_wait", 32'(input_wait), 32'd1);
        check("held_user", user_input, exp_user);
        check("held_valid", 32'(input_valid), 32'd0);
        SW    = 4'h3;
        key_n = 1'b1;
        tick(LAT + 3);
        key_n = 1'b0;
        tick(LAT);
        exp_user = 32'd3;
        check("held_cap", user_input, exp_user);
        key_n = 1'b1;
        tick(LAT);
        check("held_done", 32'(input_valid), 32'd1);
        tick(1);
        input_req = 1'b0;
        tick(2);
        check("held_pulses", 32'(pulse_cnt), 32'(base + 1));

        // Halt during WAIT_RELEASE
        r         = 4'($urandom_range(0, 15));
        SW        = r;
        input_req = 1'b1;
        tick(3);
        key_n = 1'b0;
        tick(LAT);
        exp_user = {28'd0, r};
        check("halt_cap", user_input, exp_user);
        base = pulse_cnt;
        SW   = ~r;
        halt = 1'b1;
        tick(1);
        check("halt_wait", 32'(input_wait), 32'd0);
        check("halt_valid", 32'(input_valid), 32'd0);
        check("halt_user", user_input, exp_user);
        input_req = 1'b0;
        tick(1);
        halt  = 1'b0;
        key_n = 1'b1;
        tick(LAT + 3);
        check("halt_nopulse", 32'(pulse_cnt), 32'(base));
        check("halt_idle", 32'(input_wait), 32'd0);

        // Request dropped in WAIT_PRESS
        SW        = ~SW;
        input_req = 1'b1;
        tick(3);
        check("drop_armed", 32'(input_wait), 32'd1);
        input_req = 1'b0;
        tick(1);
        check("drop_wait", 32'(input_wait), 32'd0);
        check("drop_valid", 32'(input_valid), 32'd0);
        key_n = 1'b0;
        tick(LAT + 2);
        key_n = 1'b1;
        tick(LAT + 3);
        check("drop_user", user_input, exp_user);
        check("drop_nopulse", 32'(pulse_cnt), 32'(base));

        // Back-to-back requests with a single low cycle between them
        do_read(4'd5, 3, 1);
        do_read(4'd15, 3, 2);
        check("b2b_last", user_input, 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
